// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin front end for a single shared ALU.
// Two requesters hand over operations through valid/ready. The winner's
// operands are registered onto the ALU inputs, and one cycle later the ALU
// result is captured into a response register. The response is then tagged
// for the requester that issued the operation.
module alu_share_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req0_ctrl,
    input  logic [2:0]   req1_ctrl,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_ctrl,
    input  logic [W-1:0] alu_res,
    input  logic         alu_zero,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic [W-1:0] rsp_res,
    output logic         rsp_zero,
    output logic         rsp_err
);

    // Requester-indexed views of the request ports so that per-requester
    // logic can be generated once.
    logic [1:0]   req_valid;
    logic [1:0]   grant;
    logic [1:0]   ready;
    logic [1:0]   rsp_valid_reg;

    // Issue stage (ALU input) registers.
    logic         last_grant_reg;
    logic         iss_valid_reg;
    logic         iss_id_reg;
    logic         iss_err_reg;
    logic [W-1:0] alu_a_reg;
    logic [W-1:0] alu_b_reg;
    logic [2:0]   alu_ctrl_reg;

    // Response stage registers.
    logic [W-1:0] rsp_res_reg;
    logic         rsp_zero_reg;
    logic         rsp_err_reg;

    // Selected request.
    logic         accept;
    logic         accept_id;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic [2:0]   sel_ctrl;
    logic         sel_illegal;

    assign req_valid = {req1_valid, req0_valid};

    // A requester wins if it is the only one asking, or if both ask and it
    // was not the previous winner. Ready is also held low during reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign grant[gi] = req_valid[gi] &&
                               (!req_valid[1-gi] || (last_grant_reg == 1'(1 - gi)));
            assign ready[gi] = grant[gi] && !stall && !rst;
        end
    endgenerate

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    assign accept      = |ready;
    assign accept_id   = ready[1];
    assign sel_a       = accept_id ? req1_a    : req0_a;
    assign sel_b       = accept_id ? req1_b    : req0_b;
    assign sel_ctrl    = accept_id ? req1_ctrl : req0_ctrl;
    assign sel_illegal = (sel_ctrl == 3'b011) || (sel_ctrl == 3'b100) ||
                         (sel_ctrl == 3'b101);

    // Issue register: latch the accepted op. The ALU inputs hold on idle
    // cycles so that the ALU operands do not toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            iss_valid_reg  <= 1'b0;
            iss_id_reg     <= 1'b0;
            iss_err_reg    <= 1'b0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_ctrl_reg   <= 3'b010;
        end else if (accept) begin
            last_grant_reg <= accept_id;
            iss_valid_reg  <= 1'b1;
            iss_id_reg     <= accept_id;
            iss_err_reg    <= sel_illegal;
            alu_a_reg      <= sel_a;
            alu_b_reg      <= sel_b;
            alu_ctrl_reg   <= sel_ctrl;
        end else begin
            iss_valid_reg  <= 1'b0;
        end
    end

    // Response register: capture the ALU output of the issued op and hold it
    // when nothing was issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_res_reg  <= '0;
            rsp_zero_reg <= 1'b0;
            rsp_err_reg  <= 1'b0;
        end else if (iss_valid_reg) begin
            rsp_res_reg  <= alu_res;
            rsp_zero_reg <= alu_zero;
            rsp_err_reg  <= iss_err_reg;
        end
    end

    // One-cycle response pulse, routed to the requester that issued the op.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            always_ff @(posedge clk) begin
                if (rst) begin
                    rsp_valid_reg[gi] <= 1'b0;
                end else begin
                    rsp_valid_reg[gi] <= iss_valid_reg && (iss_id_reg == 1'(gi));
                end
            end
        end
    endgenerate

    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_ctrl   = alu_ctrl_reg;
    assign rsp0_valid = rsp_valid_reg[0];
    assign rsp1_valid = rsp_valid_reg[1];
    assign rsp_res    = rsp_res_reg;
    assign rsp_zero   = rsp_zero_reg;
    assign rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: drives alu_share_arbiter with directed and random
// requests. It includes an ALU model and keeps a scoreboard of expected
// responses, built from the grant rules and pipeline latency.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_ctrl, req1_ctrl;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [2:0]  alu_ctrl;
    logic        alu_zero;
    logic        rsp0_valid, rsp1_valid, rsp_zero, rsp_err;
    logic [31:0] rsp_res;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_res(alu_res), .alu_zero(alu_zero),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_res(rsp_res), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    // Shared ALU. Illegal codes yield an arbitrary but deterministic value.
    function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a ^ b ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    function automatic logic is_illegal(logic [2:0] c);
        return (c == 3'b011) || (c == 3'b100) || (c == 3'b101);
    endfunction

    assign alu_res  = alu_fn(alu_a, alu_b, alu_ctrl);
    assign alu_zero = (alu_res == 32'd0);

    // Reference model state.
    typedef struct {
        int          due;
        logic        id;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } rsp_t;

    rsp_t        q[$];
    int          cyc = 0;
    logic        m_last = 1'b1;
    logic [31:0] m_res = '0, m_a = '0, m_b = '0;
    logic        m_zero = 1'b0, m_err = 1'b0;
    logic [2:0]  m_ctrl = 3'b010;

    // Observed and expected values for the most recent cycle.
    logic [1:0]   obs_rdy, exp_rdy;
    logic [102:0] obs_out, exp_out;

    // Drives one cycle of stimulus and samples the DUT. It then advances the
    // reference model. This task does no comparisons; callers compare.
    task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [2:0] c0, input logic v1, input logic [31:0] a1,
                        input logic [31:0] b1, input logic [2:0] c1,
                        input logic s, input logic r);
        logic [1:0] rv;
        int         win;
        rsp_t       e;
        @(negedge clk);
        rst = r; stall = s;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
        #1;
        obs_rdy = {req1_ready, req0_ready};
        obs_out = {rsp1_valid, rsp0_valid, rsp_res, rsp_zero, rsp_err, alu_a, alu_b, alu_ctrl};

        rv = 2'b00;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            rv[e.id] = 1'b1;
            m_res = e.res; m_zero = e.zero; m_err = e.err;
        end
        exp_out = {rv, m_res, m_zero, m_err, m_a, m_b, m_ctrl};

        win = -1;
        if (!r && !s) begin
            if (v0 && v1) win = (m_last == 1'b1) ? 0 : 1;
            else if (v0)  win = 0;
            else if (v1)  win = 1;
        end
        exp_rdy = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);

        if (r) begin
            q.delete();
            m_last = 1'b1; m_res = '0; m_zero = 1'b0; m_err = 1'b0;
            m_a = '0; m_b = '0; m_ctrl = 3'b010;
        end else if (win >= 0) begin
            e.due = cyc + 2;
            e.id  = (win == 1);
            if (win == 0) begin
                e.res = alu_fn(a0, b0, c0); e.err = is_illegal(c0);
                m_a = a0; m_b = b0; m_ctrl = c0;
            end else begin
                e.res = alu_fn(a1, b1, c1); e.err = is_illegal(c1);
                m_a = a1; m_b = b1; m_ctrl = c1;
            end
            e.zero = (e.res == 32'd0);
            q.push_back(e);
            m_last = e.id;
        end
        cyc++;
    endtask

    // Hold reset for two edges, then check every output for its reset value.
    task automatic test_reset();
        rst = 1'b1; stall = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_ctrl = 3'b010; req1_ctrl = 3'b010;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_ready got=%b expected=00", {req1_ready, req0_ready});
        end
        tests_run++;
        if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_rsp_valid got=%b expected=00", {rsp1_valid, rsp0_valid});
        end
        tests_run++;
        if ({alu_a, alu_b, alu_ctrl} !== {32'd0, 32'd0, 3'b010}) begin
            tests_failed++;
            $display("FAIL reset_alu got=%h/%h/%b expected=0/0/010", alu_a, alu_b, alu_ctrl);
        end
        tests_run++;
        if ({rsp_res, rsp_zero, rsp_err} !== {32'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_rsp got=%h/%b/%b expected=0/0/0", rsp_res, rsp_zero, rsp_err);
        end
    endtask

    // A single add from req0; the response is due two cycles later.
    task automatic test_single();
        for (int i = 0; i < 4; i++) begin
            step(i == 0, 32'd0, 32'hDEADBEEF, 3'b010, 1'b0, $urandom, $urandom, 3'($urandom),
                 1'b0, 1'b0);
            tests_run++;
            if (obs_rdy !== exp_rdy) begin
                tests_failed++;
                $display("FAIL single_ready cyc=%0d got=%b expected=%b", cyc - 1, obs_rdy, exp_rdy);
            end
            tests_run++;
            if (obs_out !== exp_out) begin
                tests_failed++;
                $display("FAIL single_out cyc=%0d got=%h expected=%h", cyc - 1, obs_out, exp_out);
            end
            if (i == 2) begin
                tests_run++;
                if ({rsp0_valid, rsp_res, rsp_zero, rsp_err} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL single_result got=%b/%h/%b/%b expected=1/deadbeef/0/0",
                             rsp0_valid, rsp_res, rsp_zero, rsp_err);
                end
            end
        end
    endtask

    // req0 streams and, sub, or, slt back to back.
    task automatic test_stream();
        logic [2:0] ops [4];
        ops = '{3'b000, 3'b110, 3'b001, 3'b111};
        for (int i = 0; i < 7; i++) begin
            step(i < 4, 32'd0, 32'hDEADBEEF, ops[i % 4], 1'b0, $urandom, $urandom, 3'($urandom),
                 1'b0, 1'b0);
            tests_run++;
            if (obs_rdy !== exp_rdy) begin
                tests_failed++;
                $display("FAIL stream_ready cyc=%0d got=%b expected=%b", cyc - 1, obs_rdy, exp_rdy);
            end
            tests_run++;
            if (obs_out !== exp_out) begin
                tests_failed++;
                $display("FAIL stream_out cyc=%0d got=%h expected=%h", cyc - 1, obs_out, exp_out);
            end
        end
    endtask

    // Both requesters valid continuously: grants must alternate.
    task automatic test_alternate();
        logic [2:0] ops [6];
        ops = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
        for (int i = 0; i < 9; i++) begin
            step(i < 6, $urandom, $urandom, ops[i % 6], i < 6, $urandom, $urandom,
                 ops[(i + 3) % 6], 1'b0, 1'b0);
            tests_run++;
            if (obs_rdy !== exp_rdy || obs_rdy == 2'b11) begin
                tests_failed++;
                $display("FAIL alternate_ready cyc=%0d got=%b expected=%b", cyc - 1, obs_rdy, exp_rdy);
            end
            tests_run++;
            if (obs_out !== exp_out) begin
                tests_failed++;
                $display("FAIL alternate_out cyc=%0d got=%h expected=%h", cyc - 1, obs_out, exp_out);
            end
        end
    endtask

    // An op is in flight, then stall is held for 3 cycles with both valid,
    // and then released.
    task automatic test_stall();
        for (int i = 0; i < 10; i++) begin
            step(i < 8, $urandom, $urandom, 3'b010, i < 8, $urandom, $urandom, 3'b110,
                 (i >= 1 && i <= 3), 1'b0);
            tests_run++;
            if (obs_rdy !== exp_rdy) begin
                tests_failed++;
                $display("FAIL stall_ready cyc=%0d got=%b expected=%b", cyc - 1, obs_rdy, exp_rdy);
            end
            tests_run++;
            if (obs_out !== exp_out) begin
                tests_failed++;
                $display("FAIL stall_out cyc=%0d got=%h expected=%h", cyc - 1, obs_out, exp_out);
            end
        end
    endtask

    // req1 issues illegal ctrl 101, followed by a legal op.
    task automatic test_illegal();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, $urandom, $urandom, 3'($urandom), i < 2, 32'h1234_5678, 32'h0F0F_0F0F,
                 (i == 0) ? 3'b101 : 3'b000, 1'b0, 1'b0);
            tests_run++;
            if (obs_rdy !== exp_rdy) begin
                tests_failed++;
                $display("FAIL illegal_ready cyc=%0d got=%b expected=%b", cyc - 1, obs_rdy, exp_rdy);
            end
            tests_run++;
            if (obs_out !== exp_out) begin
                tests_failed++;
                $display("FAIL illegal_out cyc=%0d got=%h expected=%h", cyc - 1, obs_out, exp_out);
            end
            if (i == 2) begin
                tests_run++;
                if ({rsp1_valid, rsp_err} !== 2'b11) begin
                    tests_failed++;
                    $display("FAIL illegal_err got=%b/%b expected=1/1", rsp1_valid, rsp_err);
                end
            end
        end
    endtask

    // Reset the cycle after accepting an op: no response appears for it.
    task automatic test_rst_mid();
        for (int i = 0; i < 5; i++) begin
            step(i < 2, $urandom, $urandom, 3'b010, 1'b0, $urandom, $urandom, 3'b010,
                 1'b0, i == 1);
            tests_run++;
            if (obs_rdy !== exp_rdy) begin
                tests_failed++;
                $display("FAIL rstmid_ready cyc=%0d got=%b expected=%b", cyc - 1, obs_rdy, exp_rdy);
            end
            tests_run++;
            if (obs_out !== exp_out) begin
                tests_failed++;
                $display("FAIL rstmid_out cyc=%0d got=%h expected=%h", cyc - 1, obs_out, exp_out);
            end
            if (i == 2) begin
                tests_run++;
                if (obs_out !== {2'b00, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b010}) begin
                    tests_failed++;
                    $display("FAIL rstmid_values got=%h expected=reset values", obs_out);
                end
            end
        end
    endtask

    // Random traffic with random stall, illegal codes and occasional reset.
    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), $urandom, $urandom, 3'($urandom),
                 1'($urandom), $urandom, $urandom, 3'($urandom),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0));
            tests_run++;
            if (obs_rdy !== exp_rdy) begin
                tests_failed++;
                $display("FAIL random_ready cyc=%0d got=%b expected=%b", cyc - 1, obs_rdy, exp_rdy);
            end
            tests_run++;
            if (obs_out !== exp_out) begin
                tests_failed++;
                $display("FAIL random_out cyc=%0d got=%h expected=%h", cyc - 1, obs_out, exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_alternate();
        test_stall();
        test_illegal();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU datapath (`ALUexec`). It accepts operations from two independent requesters over valid/ready handshakes and picks one per cycle with round-robin fairness. It registers the operands into the ALU and captures `res`/`zero` into a response register, returning each result to the requester that issued it. The block sits between the execute-stage issue logic (or a multi-cycle unit) and the single ALU instance, and it owns all of that ALU's inputs.

## Interface
- `W`, 32, operand/result width
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `stall` input 1: when high, no new request is accepted; in-flight ops still complete
- `req0_valid`, `req1_valid` input 1: requester n has an op
- `req0_ready`, `req1_ready` output 1: handshake completes on valid && ready
- `req0_a`, `req0_b`, `req1_a`, `req1_b` input W: operands
- `req0_ctrl`, `req1_ctrl` input 3: ALU op (000 and, 001 or, 010 add, 110 sub, 111 slt)
- `alu_a`, `alu_b` output W: to ALU A/B, registered
- `alu_ctrl` output 3: to ALU ctrl, registered
- `alu_res` input W: from ALU, combinational on `alu_a`/`alu_b`/`alu_ctrl`
- `alu_zero` input 1: from ALU
- `rsp0_valid`, `rsp1_valid` output 1: one-cycle pulse; result belongs to requester n
- `rsp_res` output W: registered result
- `rsp_zero` output 1: registered zero flag
- `rsp_err` output 1: op used an illegal ctrl code (011, 100, 101)

## Operation
- Grant (combinational): only one valid → that requester. Both valid → requester != `last_grant`. Neither valid → no grant.
- `reqN_ready = grantN && !stall`. At most one ready is high per cycle. Ready never depends on the other requester's ready.
- On accept: latch a, b, ctrl into the issue register (`alu_a`, `alu_b`, `alu_ctrl`). Set `iss_valid` = 1, `iss_id` = N, `iss_err` = (ctrl illegal). Update `last_grant` = N.
- No accept this cycle: `iss_valid` = 0. `alu_*` hold their last values; no operand toggling on idle cycles.
- Response stage: if `iss_valid`, capture `alu_res` into `rsp_res`, `alu_zero` into `rsp_zero`, `iss_err` into `rsp_err`. Pulse `rsp<iss_id>_valid` for 1 cycle. Otherwise both rsp valids are 0 and `rsp_res`/`rsp_zero`/`rsp_err` hold.
- Illegal ctrl codes are still issued to the ALU. The result is returned unchanged with `rsp_err` = 1, and the arbiter is not blocked.
- No response backpressure: requesters must consume `rsp*_valid` when it pulses.
- Arithmetic: no width conversion; `rsp_res` is exactly W bits from the ALU.
- Effective pipeline: IDLE (no `iss_valid`) / ISSUE (`iss_valid`) / RESPOND (rsp pulse). Back-to-back accepts overlap ISSUE and RESPOND.

## Timing
- Reset values: `last_grant` = 1 (so req0 wins the first tie), `iss_valid` = 0, `alu_a` = 0, `alu_b` = 0, `alu_ctrl` = 3'b010, `rsp0_valid` = 0, `rsp1_valid` = 0, `rsp_res` = 0, `rsp_zero` = 0, `rsp_err` = 0.
- Latency: handshake in cycle N → operands on `alu_*` in cycle N+1 → `rsp*_valid`, `rsp_res` valid in cycle N+2.
- Throughput: 1 op/cycle. With both requesters continuously valid, grants strictly alternate 0,1,0,1,…
- `stall` rising in cycle N blocks acceptance in N only. Ops accepted in N-1 and N-2 still respond in N+1 and N. Stall does not change `last_grant`.
- Request deasserted in the same cycle as a tie: only registered `last_grant` matters; there is no lookahead.
- `rst` high mid-operation: all in-flight ops are discarded, no `rsp*_valid` pulse in the cycle after reset, and both readies are low while `rst` is high.
- The requester-side handshake inputs are sampled only on the rising edge; combinational changes to a/b/ctrl while not ready are ignored.

## Test plan
- Reset, then req0 only, A=0, B=0xDEADBEEF, ctrl=010 at cycle 0 → `rsp0_valid` at cycle 2, `rsp_res`=0xDEADBEEF, `rsp_zero`=0, `rsp_err`=0.
- req0 streams and, sub, or, slt with A=0, B=0xDEADBEEF, one per cycle → responses in order, one cycle apart: 0/zero=1, 0x21524111/zero=0, 0xDEADBEEF/zero=0, 0/zero=1.
- Both valid continuously for 6 cycles with distinct ops → grants 0,1,0,1,0,1. Each rsp pulse is on the matching `rspN_valid` with the correct result, and no cycle has both readies high.
- `stall` high for 3 cycles while both are valid, with one op in flight → no readies for 3 cycles, the in-flight op still responds, and alternation resumes from the pre-stall `last_grant`.
- req1 issues ctrl=101 → the response arrives with `rsp1_valid`=1 and `rsp_err`=1. The next legal op accepted in the following cycle responds with `rsp_err`=0.
- Assert `rst` the cycle after accepting an op → no `rsp*_valid` pulse ever appears for that op, and all outputs read their reset values one cycle after `rst`.
